// File: rtl/bram_row_reader_512b.sv
// Fetches one 512-bit row as sixteen 32-bit BRAM word reads and returns it over a level trig/done handshake.
// Each word is a full trig/done round trip; a stuck handshake phase aborts the row with o_err set.
module bram_row_reader_512b #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_trig,
    input  logic [8:0]   i_row_num,
    output logic         o_done,
    output logic         o_err,
    output logic [511:0] o_row_512b,
    output logic [12:0]  o_rd_from_bram_addr,
    output logic         o_rd_from_bram_trig,
    input  logic [31:0]  i_rd_from_bram_data,
    input  logic         i_rd_from_bram_done
);

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RELEASE,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [8:0]  row;
    logic [3:0]  word;
    logic [7:0]  tmo_cnt;
    logic        accept;
    logic        capture;
    logic        advance;
    logic        timeout;
    logic        tmo_hit;

    assign tmo_hit = (tmo_cnt == TMO_LIMIT);

    // A completed handshake phase wins over a timeout landing on the same cycle.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        advance   = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (i_trig) begin
                    accept    = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (i_rd_from_bram_done) begin
                    capture   = 1'b1;
                    state_nxt = RELEASE;
                end else if (tmo_hit) begin
                    timeout   = 1'b1;
                    state_nxt = DONE;
                end
            end
            RELEASE: begin
                if (!i_rd_from_bram_done) begin
                    if (word == 4'd15) begin
                        state_nxt = DONE;
                    end else begin
                        advance   = 1'b1;
                        state_nxt = REQ;
                    end
                end else if (tmo_hit) begin
                    timeout   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (!i_trig) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            row                 <= '0;
            word                <= '0;
            tmo_cnt             <= '0;
            o_done              <= 1'b0;
            o_err               <= 1'b0;
            o_row_512b          <= '0;
            o_rd_from_bram_addr <= '0;
            o_rd_from_bram_trig <= 1'b0;
        end else begin
            o_rd_from_bram_trig <= (state_nxt == REQ);
            o_done              <= (state_nxt == DONE);

            if (accept) begin
                row                 <= i_row_num;
                word                <= 4'd0;
                o_err               <= 1'b0;
                o_rd_from_bram_addr <= {i_row_num, 4'd0};
            end

            if (advance) begin
                word                <= word + 4'd1;
                o_rd_from_bram_addr <= {row, word + 4'd1};
            end

            if (timeout) begin
                o_err <= 1'b1;
            end

            // Word 0 lands in the top slice: {~word, 5'd0} is 480 for word 0, 0 for word 15.
            if (capture) begin
                o_row_512b[{~word, 5'd0} +: 32] <= i_rd_from_bram_data;
            end

            if (accept || capture || advance) begin
                tmo_cnt <= '0;
            end else if ((state == REQ || state == RELEASE) && !tmo_hit) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_bram_row_reader_512b.sv
// Randomised bench for bram_row_reader_512b: BRAM controller model, address and row scoreboards.
// Inputs change on the falling clock edge; outputs are sampled 1ns after the rising edge.
module tb_bram_row_reader_512b;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         trig = 1'b0;
    logic [8:0]   row_num = '0;
    logic         done;
    logic         err;
    logic [511:0] row_out;
    logic [12:0]  rd_addr;
    logic         rd_trig;
    logic [31:0]  rd_data = '0;
    logic         rd_done = 1'b0;

    int total = 0;
    int bad = 0;

    logic [31:0]  mem [0:8191];
    logic [511:0] ref_row = '0;
    logic [12:0]  exp_addr [$];
    logic [511:0] exp_row [$];
    logic         exp_err [$];

    logic         rand_dly = 1'b0;
    logic         stall_en = 1'b0;
    logic [12:0]  stall_addr = '0;

    always #5 clk = ~clk;

    bram_row_reader_512b #(.TIMEOUT_CYCLES(255)) dut (
        .i_clk               (clk),
        .i_rstn              (rst_n),
        .i_trig              (trig),
        .i_row_num           (row_num),
        .o_done              (done),
        .o_err               (err),
        .o_row_512b          (row_out),
        .o_rd_from_bram_addr (rd_addr),
        .o_rd_from_bram_trig (rd_trig),
        .i_rd_from_bram_data (rd_data),
        .i_rd_from_bram_done (rd_done)
    );

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Controller model: raises done dly cycles after seeing trig, drops it dly cycles after trig falls.
    initial begin
        int cnt;
        int dly;
        cnt = 0;
        dly = 1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rd_done = 1'b0;
                cnt = 0;
            end else if (!rd_done) begin
                if (rd_trig && !(stall_en && rd_addr == stall_addr)) begin
                    if (cnt >= dly) begin
                        rd_done = 1'b1;
                        rd_data = mem[rd_addr];
                        cnt = 0;
                        dly = rand_dly ? int'($urandom_range(0, 7)) : 1;
                    end else begin
                        cnt++;
                    end
                end else begin
                    cnt = 0;
                end
            end else begin
                if (!rd_trig) begin
                    if (cnt >= dly) begin
                        rd_done = 1'b0;
                        rd_data = $urandom;
                        cnt = 0;
                        dly = rand_dly ? int'($urandom_range(0, 7)) : 1;
                    end else begin
                        cnt++;
                    end
                end else begin
                    cnt = 0;
                end
            end
        end
    end

    // Address monitor: each new trig must follow a released done and carry the next expected address.
    initial begin
        logic prev_t;
        logic [12:0] a;
        prev_t = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rd_trig && !prev_t) begin
                chk("trig_after_release", 512'(rd_done), 512'(0));
                chk("addr_expected", 512'(exp_addr.size() > 0), 512'(1));
                if (exp_addr.size() > 0) begin
                    a = exp_addr.pop_front();
                    chk("rd_addr", 512'(rd_addr), 512'(a));
                end
            end
            prev_t = rd_trig;
        end
    end

    // Response monitor: on each o_done rise compare row and error flag with the model.
    initial begin
        logic prev_d;
        logic [511:0] r;
        logic e;
        prev_d = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (done && !prev_d) begin
                chk("resp_expected", 512'(exp_row.size() > 0), 512'(1));
                if (exp_row.size() > 0) begin
                    r = exp_row.pop_front();
                    e = exp_err.pop_front();
                    chk("row_data", row_out, r);
                    chk("row_err", 512'(err), 512'(e));
                end
            end
            prev_d = done;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    // Updates the reference row and queues; stall_w < 16 names a word the controller never acks.
    task automatic start_row(input logic [8:0] r, input int stall_w);
        int last;
        int nw;
        last = (stall_w < 16) ? stall_w : 15;
        nw   = (stall_w < 16) ? stall_w : 16;
        for (int k = 0; k <= last; k++) exp_addr.push_back({r, 4'(k)});
        for (int k = 0; k < nw; k++) ref_row[511 - 32*k -: 32] = mem[{r, 4'(k)}];
        exp_row.push_back(ref_row);
        exp_err.push_back(stall_w < 16);
        stall_en   = (stall_w < 16);
        stall_addr = {r, 4'(stall_w)};
        @(negedge clk);
        row_num = r;
        trig = 1'b1;
    endtask

    task automatic wait_done(input int start, output int lat);
        lat = start;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!done && lat < 3000);
        chk("done_within_budget", 512'(done), 512'(1));
    endtask

    task automatic wait_addr(input logic [12:0] a);
        int n;
        n = 0;
        while (!(rd_trig && rd_addr == a) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("addr_within_budget", 512'(n < 2000), 512'(1));
    endtask

    task automatic end_row();
        @(negedge clk);
        trig = 1'b0;
        @(posedge clk);
        #1;
        chk("done_drop", 512'(done), 512'(0));
    endtask

    initial begin
        int lat;
        int hi;
        logic [511:0] prev;

        for (int i = 0; i < 8192; i++) mem[i] = $urandom;
        for (int k = 0; k < 16; k++) mem[k] = 32'hA5A50000 + 32'(k);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_done", 512'(done), 512'(0));
        chk("reset_err", 512'(err), 512'(0));
        chk("reset_trig", 512'(rd_trig), 512'(0));
        chk("reset_addr", 512'(rd_addr), 512'(0));
        chk("reset_row", row_out, 512'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Row 0, fixed one-cycle controller.
        start_row(9'd0, 16);
        @(posedge clk);
        #1;
        chk("cycle1_trig", 512'(rd_trig), 512'(1));
        chk("cycle1_addr", 512'(rd_addr), 512'(0));
        wait_done(1, lat);
        chk("row0_latency", 512'(lat), 512'(65));
        chk("row0_word0", 512'(row_out[511:480]), 512'(32'hA5A50000));
        chk("row0_word15", 512'(row_out[31:0]), 512'(32'hA5A5000F));
        end_row();

        // Row 511, random handshake delays.
        rand_dly = 1'b1;
        start_row(9'd511, 16);
        wait_done(0, lat);
        end_row();
        rand_dly = 1'b0;

        // Word 5 of row 7 never acknowledged.
        prev = ref_row;
        start_row(9'd7, 5);
        wait_done(0, lat);
        chk("timeout_trig_low", 512'(rd_trig), 512'(0));
        chk("timeout_low_bits_kept", 512'(row_out[351:0]), 512'(prev[351:0]));
        end_row();

        // i_trig dropped during word 3 of row 3.
        start_row(9'd3, 16);
        wait_addr({9'd3, 4'd3});
        @(negedge clk);
        trig = 1'b0;
        wait_done(0, lat);
        hi = 0;
        while (done && hi < 10) begin
            hi++;
            @(posedge clk);
            #1;
        end
        chk("done_pulse_len", 512'(hi), 512'(1));
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after_pulse", 512'(rd_trig), 512'(0));

        // Reset during word 9 of row 4, then a fresh read of row 2.
        start_row(9'd4, 16);
        wait_addr({9'd4, 4'd9});
        @(negedge clk);
        rst_n = 1'b0;
        trig = 1'b0;
        #1;
        chk("midrst_trig", 512'(rd_trig), 512'(0));
        chk("midrst_done", 512'(done), 512'(0));
        chk("midrst_row", row_out, 512'(0));
        exp_addr.delete();
        exp_row.delete();
        exp_err.delete();
        ref_row = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        start_row(9'd2, 16);
        wait_done(0, lat);
        end_row();

        // Back-to-back rows 10 and 11.
        start_row(9'd10, 16);
        wait_done(0, lat);
        prev = ref_row;
        end_row();
        chk("row10_stable_idle", row_out, prev);
        start_row(9'd11, 16);
        @(posedge clk);
        #1;
        chk("row11_cycle1_addr", 512'(rd_addr), 512'(13'h0B0));
        chk("row10_stable_accept", row_out, prev);
        wait_done(1, lat);
        chk("row11_latency", 512'(lat), 512'(65));
        end_row();

        repeat (3) @(posedge clk);
        #1;
        chk("addr_queue_drained", 512'(exp_addr.size()), 512'(0));
        chk("resp_queue_drained", 512'(exp_row.size()), 512'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
